// File: rtl/can_bit_tx.sv
// Bit-level CAN/UART-style serial transmitter with optional stuff-bit insertion
// and sample-point readback for arbitration-loss and bit-error detection.
module can_bit_tx #(
  parameter int COUNTER_WIDTH = 24,
  parameter int DATA_WIDTH    = 64,
  parameter int LEN_WIDTH     = 7
) (
  input  logic                     sampleclk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] count_max,
  input  logic [COUNTER_WIDTH-1:0] sample_pt,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic [LEN_WIDTH-1:0]     len,
  input  logic [LEN_WIDTH-1:0]     arb_bits,
  input  logic                     stuff_en,
  input  logic                     rx,
  output logic                     tx,
  output logic                     bit_clk,
  output logic                     busy,
  output logic                     done,
  output logic                     arb_lost,
  output logic                     bit_error
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [2:0]               run;
  logic [DATA_WIDTH-1:0]    shift_reg;
  logic [LEN_WIDTH-1:0]     len_r;
  logic [LEN_WIDTH-1:0]     arb_r;
  logic [LEN_WIDTH-1:0]     sent;
  logic                     stuff_r;

  logic       at_sample;
  logic       at_end;
  logic       in_arb;
  logic       need_stuff;
  logic       last_bit;
  logic       next_bit;
  logic [2:0] next_run;

  // sent counts data bits consumed including the one on the line, so a stuff
  // bit ahead of data bit arb_bits and data bits below arb_bits share one test.
  assign at_sample  = (counter == sample_pt);
  assign at_end     = (counter == count_max);
  assign in_arb     = (sent <= arb_r);
  assign need_stuff = stuff_r && (run == 3'd5);
  assign last_bit   = !need_stuff && (sent == len_r);
  assign next_bit   = need_stuff ? ~tx : shift_reg[DATA_WIDTH-1];
  assign bit_clk    = (state == SEND) && (counter > (count_max >> 1));

  always_comb begin
    next_run = 3'd1;
    if (!need_stuff && (next_bit == tx)) begin
      next_run = (run == 3'd7) ? run : run + 3'd1;
    end
  end

  always_ff @(posedge sampleclk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      arb_lost  <= 1'b0;
      bit_error <= 1'b0;
      counter   <= '0;
      run       <= '0;
      shift_reg <= '0;
      len_r     <= '0;
      arb_r     <= '0;
      sent      <= '0;
      stuff_r   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          counter <= '0;
          if (start) begin
            len_r     <= len;
            arb_r     <= arb_bits;
            stuff_r   <= stuff_en;
            arb_lost  <= 1'b0;
            bit_error <= 1'b0;
            shift_reg <= data << 1;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state <= SEND;
              busy  <= 1'b1;
              tx    <= data[DATA_WIDTH-1];
              run   <= 3'd1;
              sent  <= LEN_WIDTH'(1);
            end
          end
        end
        SEND: begin
          // A readback mismatch aborts the frame before any bit advance.
          if (at_sample && (rx != tx)) begin
            if (tx && !rx && in_arb) begin
              arb_lost <= 1'b1;
            end else begin
              bit_error <= 1'b1;
            end
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            counter <= '0;
          end else if (at_end) begin
            counter <= '0;
            if (last_bit) begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              tx  <= next_bit;
              run <= next_run;
              if (!need_stuff) begin
                shift_reg <= shift_reg << 1;
                sent      <= sent + LEN_WIDTH'(1);
              end
            end
          end else begin
            counter <= counter + COUNTER_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
